div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the execute stage, directly downstream of the ALU control decode. When the decoded operation is DIV or DIVU, the ALU raises `start` and stalls the pipeline until `ready`. The block computes quotient and remainder with a radix-2 restoring algorithm and returns them as a 64-bit {HI, LO} pair for the HI/LO register write.

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 142 ++++++++++++++
 tb/tb_div_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Handshake and data bundle between the execute-stage ALU and the divider.
// Master drives the request (start/operands/annul); slave returns result/ready/busy.
// Single clock domain; all signals are sampled on the divider clock.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 busy;

    modport master (
        output start, signed_div, a, b, annul,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, a, b, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider returning {remainder, quotient} = {HI, LO}.
// Latency: WIDTH cycles start-to-ready (1 cycle for b==0 when DIV_ZERO_FAST_EN is defined).
// Backpressure: none; requester stalls on busy, start accepted in IDLE/DONE, annul aborts.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Latched operation context
    logic               sdiv;
    logic               sgn_a;
    logic               sgn_x;
    logic               dz;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   b_mag;

    // Iteration state: partial remainder and dividend/quotient shift register
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] result_q;

    // Combinational datapath
    logic [WIDTH+1:0]   rem_sh;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH:0]     rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] res_nx;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic               load;
    logic               last;
    logic               fin;

    assign load = (state != RUN) && bus.start && !bus.annul;
    assign last = (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
    // A zero divisor leaves RUN after a single cycle; the result does not depend on the iterations.
    assign fin = last || dz;
`else
    assign fin = last;
`endif

    // Operand magnitudes: only signed requests take the absolute value.
    always_comb begin
        a_abs = bus.a;
        b_abs = bus.b;
        if (bus.signed_div && bus.a[WIDTH-1]) a_abs = -bus.a;
        if (bus.signed_div && bus.b[WIDTH-1]) b_abs = -bus.b;
    end

    // One restoring step plus the sign fix-up used when the last step completes.
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        trial  = rem_sh - {2'b00, b_mag};
        rem_nx = trial[WIDTH:0];
        quo_nx = {quo[WIDTH-2:0], 1'b1};
        if (trial[WIDTH+1]) begin
            rem_nx = rem_sh[WIDTH:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        q_fix = quo_nx;
        r_fix = rem_nx[WIDTH-1:0];
        if (sdiv && sgn_x) q_fix = -quo_nx;
        if (sdiv && sgn_a) r_fix = -rem_nx[WIDTH-1:0];
        res_nx = {r_fix, q_fix};
        // Divide by zero returns the raw dividend in HI and all-ones in LO.
        if (dz) res_nx = {a_raw, {WIDTH{1'b1}}};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: annul beats start; start during RUN is ignored.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = load ? RUN : IDLE;
            RUN: begin
                if (bus.annul)  state_nx = IDLE;
                else if (fin)   state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration and result registration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdiv     <= 1'b0;
            sgn_a    <= 1'b0;
            sgn_x    <= 1'b0;
            dz       <= 1'b0;
            a_raw    <= '0;
            b_mag    <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else if (load) begin
            sdiv  <= bus.signed_div;
            sgn_a <= bus.a[WIDTH-1];
            sgn_x <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            dz    <= (bus.b == '0);
            a_raw <= bus.a;
            b_mag <= b_abs;
            quo   <= a_abs;
            rem   <= '0;
            cnt   <= '0;
        end else if (state == RUN && !bus.annul) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt + CW'(1);
            if (fin) result_q <= res_nx;
        end
    end

    // Status decodes straight from the state register, so no input reaches them combinationally.
    assign bus.ready  = (state == DONE);
    assign bus.busy   = (state == RUN);
    assign bus.result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random checks of div_unit against an arithmetic reference model.
// Covers latency, sign rules, divide by zero, overflow, annul, back-to-back and reset.
// Optional fast divide-by-zero latency follows DIV_ZERO_FAST_EN.
module tb_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(W)) dif ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] last_res;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, C-style truncating division.
    function automatic logic [63:0] model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sd ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sd ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        return (b == 32'd0) ? 1 : 32;
`else
        return 32;
`endif
    endfunction

    // Call at a negedge; returns at the negedge where ready is observed (the DONE cycle).
    task automatic run_div(input string tag, input logic sd, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int k;
        int busy_cnt;
        bit got;
        dif.start      = 1'b1;
        dif.signed_div = sd;
        dif.a          = a;
        dif.b          = b;
        busy_cnt       = 0;
        got            = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) dif.start = 1'b0;
            if (dif.ready && dif.busy) chk({tag, "_excl"}, 64'(dif.ready & dif.busy), 64'd0);
            if (dif.busy) busy_cnt++;
            if (dif.ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_lat"}, 64'(k - 1), 64'(exp_lat(b)));
            chk({tag, "_busy"}, 64'(busy_cnt), 64'(exp_lat(b)));
            chk({tag, "_res"}, dif.result, exp);
            last_res = exp;
        end
    endtask

    // One idle cycle after a completion: ready must have been a single pulse.
    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(dif.ready), 64'd0);
        chk({tag, "_hold"}, dif.result, last_res);
    endtask

    task automatic watch_no_ready(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dif.ready) pulses++;
        end
        chk({tag, "_noready"}, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic        sd;
        logic [31:0] ra, rb;
        int          sel;

        dif.start      = 1'b0;
        dif.signed_div = 1'b0;
        dif.a          = '0;
        dif.b          = '0;
        dif.annul      = 1'b0;
        last_res       = '0;
        rst            = 1'b0;
        #2 rst = 1'b1;
        #10;
        chk("rst_result", dif.result, 64'd0);
        chk("rst_ready", 64'(dif.ready), 64'd0);
        chk("rst_busy", 64'(dif.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases with hand-derived expectations
        run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        idle_check("u100_7");
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        idle_check("s_m7_2");
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        idle_check("s_7_m2");
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
        idle_check("s_ovf");
        run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0});
        idle_check("u_ovf");
        run_div("u_dz", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        idle_check("u_dz");
        run_div("s_dz", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF});
        idle_check("s_dz");

        // Back-to-back: second start lands in the DONE cycle of the first
        run_div("b2b_1", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
        run_div("b2b_2", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10});
        idle_check("b2b");

        // Annul ten cycles into RUN
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd1000; dif.b = 32'd3;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("annul_busy_pre", 64'(dif.busy), 64'd1);
        dif.annul = 1'b1;
        @(negedge clk);
        dif.annul = 1'b0;
        chk("annul_busy", 64'(dif.busy), 64'd0);
        chk("annul_result", dif.result, last_res);
        watch_no_ready("annul", 40);
        chk("annul_hold", dif.result, last_res);

        // Annul together with start drops the request
        dif.start = 1'b1; dif.annul = 1'b1;
        @(negedge clk);
        dif.start = 1'b0; dif.annul = 1'b0;
        chk("annul_start_busy", 64'(dif.busy), 64'd0);
        watch_no_ready("annul_start", 36);

        run_div("post_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});
        idle_check("post_annul");

        // Random operands against the model, mixing back-to-back and idle gaps
        for (int i = 0; i < 24; i++) begin
            sd  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_div($sformatf("rnd%0d", i), sd, ra, rb, model(sd, ra, rb));
            if (i % 3 == 2) idle_check($sformatf("rnd%0d", i));
        end
        idle_check("rnd_end");

        // Reset mid-RUN clears everything at once
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd100; dif.b = 32'd7;
        @(negedge clk);
        dif.start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_result", dif.result, 64'd0);
        chk("mid_rst_ready", 64'(dif.ready), 64'd0);
        chk("mid_rst_busy", 64'(dif.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_ready("mid_rst", 40);
        chk("mid_rst_hold", dif.result, 64'd0);
        last_res = '0;

        run_div("post_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        idle_check("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
